// File: rtl/draw_grid_arbiter_pkg.sv
// Shared types and geometry for the battleship draw-grid arbiter.
package draw_grid_arbiter_pkg;

  localparam int GRID_W     = 10;
  localparam int GRID_H     = 10;
  localparam int GRID_CELLS = GRID_W * GRID_H;
  localparam int ADDR_W     = 7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } grid_status_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_SHOOT = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } grid_op_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CHK,
    CLR,
    DONE
  } arb_state_t;

  // A shot turns a ship into a hit and open water into a miss; resolved cells stay put.
  function automatic grid_status_t shot_result(input grid_status_t old_status);
    grid_status_t res;
    res = old_status;
    if (old_status == SHIP) begin
      res = HIT;
    end else if (old_status == EMPTY) begin
      res = MISS;
    end
    return res;
  endfunction

endpackage

// File: rtl/draw_grid_arbiter_grid_ram.sv
// Single-port grid storage: one read or one write per cycle, one-cycle read latency.
module grid_ram
  import draw_grid_arbiter_pkg::*;
#(
  parameter int DEPTH = GRID_CELLS
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        wdata,
  output logic [1:0]        rdata
);

  logic [1:0] mem [DEPTH];

  // Synchronous access; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/draw_grid_arbiter.sv
// Shares the grid storage port between the VGA display reader and game-logic requests.
module draw_grid_arbiter
  import draw_grid_arbiter_pkg::*;
#(
  parameter int GRID_W = draw_grid_arbiter_pkg::GRID_W,
  parameter int GRID_H = draw_grid_arbiter_pkg::GRID_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [1:0]        disp_status,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_data,
  output logic              resp_valid,
  output logic [1:0]        resp_status,
  output logic              resp_err,
  output logic              busy
);

  localparam int                CELLS     = GRID_W * GRID_H;
  localparam logic [ADDR_W:0]   CELLS_EXT = (ADDR_W + 1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        data_q, data_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        resp_status_q, resp_status_d;
  logic              resp_err_q, resp_err_d;
  logic              disp_valid_q, disp_valid_d;

  logic              fsm_en, fsm_we;
  logic [ADDR_W-1:0] fsm_addr;
  logic [1:0]        fsm_wdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_wdata, ram_rdata;

  logic              disp_in_range, req_in_range;
  grid_status_t      old_status, new_status;

  assign disp_in_range = {1'b0, disp_addr} < CELLS_EXT;
  assign req_in_range  = {1'b0, req_addr} < CELLS_EXT;
  assign old_status    = grid_status_t'(ram_rdata);
  assign new_status    = shot_result(old_status);

  assign req_ready   = (state_q == IDLE) && rst;
  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_status = resp_status_q;
  assign resp_err    = resp_err_q;
  assign disp_status = disp_valid_q ? ram_rdata : EMPTY;
  assign disp_valid_d = disp_en && disp_in_range;

  // State and datapath registers; the grid array itself is left untouched by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      data_q        <= EMPTY;
      cnt_q         <= '0;
      resp_status_q <= EMPTY;
      resp_err_q    <= 1'b0;
      disp_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      resp_status_q <= resp_status_d;
      resp_err_q    <= resp_err_d;
      disp_valid_q  <= disp_valid_d;
    end
  end

  // Next-state and storage requests; the FSM only touches the port when the display is idle.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    resp_status_d = resp_status_q;
    resp_err_d    = resp_err_q;
    fsm_en        = 1'b0;
    fsm_we        = 1'b0;
    fsm_addr      = addr_q;
    fsm_wdata     = data_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d     = req_addr;
          data_d     = req_data;
          resp_err_d = 1'b0;
          if (req_op == OP_RSVD || (req_op != OP_CLEAR && !req_in_range)) begin
            resp_err_d    = 1'b1;
            resp_status_d = EMPTY;
            state_d       = DONE;
          end else if (req_op == OP_WRITE) begin
            resp_status_d = req_data;
            state_d       = WR;
          end else if (req_op == OP_SHOOT) begin
            state_d = RD;
          end else begin
            resp_status_d = EMPTY;
            cnt_d         = '0;
            state_d       = CLR;
          end
        end
      end
      WR: begin
        if (!disp_en) begin
          fsm_en  = 1'b1;
          fsm_we  = 1'b1;
          state_d = DONE;
        end
      end
      RD: begin
        if (!disp_en) begin
          fsm_en  = 1'b1;
          state_d = CHK;
        end
      end
      CHK: begin
        resp_status_d = old_status;
        if (new_status != old_status) begin
          data_d  = new_status;
          state_d = WR;
        end else begin
          state_d = DONE;
        end
      end
      CLR: begin
        fsm_addr  = cnt_q;
        fsm_wdata = EMPTY;
        if (!disp_en) begin
          fsm_en = 1'b1;
          fsm_we = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port mux: the display reader always wins the single storage port.
  always_comb begin
    ram_en    = fsm_en;
    ram_we    = fsm_we;
    ram_addr  = fsm_addr;
    ram_wdata = fsm_wdata;
    if (disp_en) begin
      ram_en    = disp_in_range;
      ram_we    = 1'b0;
      ram_addr  = disp_addr;
      ram_wdata = EMPTY;
    end
  end

  grid_ram #(
    .DEPTH(CELLS)
  ) u_grid_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_draw_grid_arbiter.sv
// Directed testbench for draw_grid_arbiter with hand-computed expectations.
module tb_draw_grid_arbiter;

  logic       clk;
  logic       rst;
  logic       disp_en;
  logic [6:0] disp_addr;
  logic [1:0] disp_status;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [6:0] req_addr;
  logic [1:0] req_data;
  logic       resp_valid;
  logic [1:0] resp_status;
  logic       resp_err;
  logic       busy;

  int error_count = 0;
  int check_count = 0;

  // Expected grid contents, updated by hand after each operation.
  logic [1:0] model [100];

  int         lat;
  logic [1:0] rstat;
  logic       rerr;

  draw_grid_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .disp_en    (disp_en),
    .disp_addr  (disp_addr),
    .disp_status(disp_status),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_status(resp_status),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one request and returns once the accepting clock edge has passed.
  task automatic acceptRequest(input logic [1:0] op, input logic [6:0] addr, input logic [1:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) checkOutput("ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_addr  = 7'd0;
    req_data  = 2'd0;
  endtask

  // Issues a request, optionally stalls with display reads, measures response latency.
  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] addr, input logic [1:0] data,
                               input int stall, output int latency, output logic [1:0] status,
                               output logic err);
    logic got;
    logic prev_disp;
    int   prev_addr;
    acceptRequest(op, addr, data);
    latency   = 1;
    got       = 1'b0;
    prev_disp = 1'b0;
    prev_addr = 0;
    status    = 2'd0;
    err       = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("busy_after_accept", 32'(busy), 1);
      if (prev_disp) checkOutput("stall_disp_status", 32'(disp_status), 32'(model[prev_addr]));
      if (resp_valid) begin
        got    = 1'b1;
        status = resp_status;
        err    = resp_err;
      end else begin
        prev_disp = (k < stall);
        prev_addr = 20 + k;
        disp_en   = prev_disp;
        disp_addr = 7'(prev_addr);
        @(posedge clk);
        latency++;
      end
    end
    disp_en = 1'b0;
    if (!got) begin
      checkOutput("resp_timeout", 0, 1);
    end else begin
      @(negedge clk);
      checkOutput("resp_pulse_one_cycle", 32'(resp_valid), 0);
    end
  endtask

  // Single display read, compared one cycle after presenting the address.
  task automatic displayCheck(input string tag, input logic [6:0] addr, input logic [1:0] expected);
    @(negedge clk);
    disp_en   = 1'b1;
    disp_addr = addr;
    @(negedge clk);
    disp_en = 1'b0;
    checkOutput(tag, 32'(disp_status), 32'(expected));
  endtask

  task automatic sweepModel(input string tag);
    for (int i = 0; i < 100; i++) begin
      displayCheck(tag, 7'(i), model[i]);
    end
  endtask

  initial begin
    rst       = 1'b0;
    disp_en   = 1'b0;
    disp_addr = 7'd0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_addr  = 7'd0;
    req_data  = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_resp_valid", 32'(resp_valid), 0);
    checkOutput("reset_resp_status", 32'(resp_status), 0);
    checkOutput("reset_resp_err", 32'(resp_err), 0);
    checkOutput("reset_disp_status", 32'(disp_status), 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_req_ready", 32'(req_ready), 1);
    checkOutput("post_reset_busy", 32'(busy), 0);

    // Clear the whole grid
    applyStimulus(2'd2, 7'd0, 2'd0, 0, lat, rstat, rerr);
    checkOutput("clear_latency", lat, 101);
    checkOutput("clear_status", 32'(rstat), 0);
    checkOutput("clear_err", 32'(rerr), 0);
    for (int i = 0; i < 100; i++) model[i] = 2'd0;
    sweepModel("clear_sweep");
    displayCheck("disp_out_of_range", 7'd100, 2'd0);

    // Place a ship and shoot it twice
    applyStimulus(2'd0, 7'd23, 2'd1, 0, lat, rstat, rerr);
    checkOutput("write23_latency", lat, 2);
    checkOutput("write23_status", 32'(rstat), 1);
    model[23] = 2'd1;
    displayCheck("write23_disp", 7'd23, 2'd1);
    applyStimulus(2'd1, 7'd23, 2'd0, 0, lat, rstat, rerr);
    checkOutput("shoot23_latency", lat, 4);
    checkOutput("shoot23_status", 32'(rstat), 1);
    checkOutput("shoot23_err", 32'(rerr), 0);
    model[23] = 2'd2;
    displayCheck("shoot23_disp", 7'd23, 2'd2);
    @(negedge clk);
    checkOutput("disp_idle_empty", 32'(disp_status), 0);
    applyStimulus(2'd1, 7'd23, 2'd0, 0, lat, rstat, rerr);
    checkOutput("reshoot23_latency", lat, 3);
    checkOutput("reshoot23_status", 32'(rstat), 2);

    // Shoot open water, then shoot the resulting miss
    applyStimulus(2'd1, 7'd5, 2'd0, 0, lat, rstat, rerr);
    checkOutput("shoot5_latency", lat, 4);
    checkOutput("shoot5_status", 32'(rstat), 0);
    model[5] = 2'd3;
    displayCheck("shoot5_disp", 7'd5, 2'd3);
    applyStimulus(2'd1, 7'd5, 2'd0, 0, lat, rstat, rerr);
    checkOutput("reshoot5_latency", lat, 3);
    checkOutput("reshoot5_status", 32'(rstat), 3);

    // Write stalled by ten display cycles
    applyStimulus(2'd0, 7'd7, 2'd1, 10, lat, rstat, rerr);
    checkOutput("stall_write_latency", lat, 12);
    checkOutput("stall_write_status", 32'(rstat), 1);
    model[7] = 2'd1;
    displayCheck("stall_write_disp", 7'd7, 2'd1);

    // Last valid cell, then error cases
    applyStimulus(2'd0, 7'd99, 2'd3, 0, lat, rstat, rerr);
    checkOutput("write99_latency", lat, 2);
    checkOutput("write99_err", 32'(rerr), 0);
    model[99] = 2'd3;
    applyStimulus(2'd0, 7'd100, 2'd1, 0, lat, rstat, rerr);
    checkOutput("bad_addr_latency", lat, 1);
    checkOutput("bad_addr_err", 32'(rerr), 1);
    applyStimulus(2'd1, 7'd127, 2'd0, 0, lat, rstat, rerr);
    checkOutput("bad_shoot_err", 32'(rerr), 1);
    applyStimulus(2'd3, 7'd10, 2'd1, 0, lat, rstat, rerr);
    checkOutput("rsvd_op_latency", lat, 1);
    checkOutput("rsvd_op_err", 32'(rerr), 1);
    sweepModel("after_errors_sweep");

    // Reset in the middle of a clear, after cells 0..49 are written
    acceptRequest(2'd2, 7'd0, 2'd0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_resp_valid", 32'(resp_valid), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_req_ready", 32'(req_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 32'(resp_valid), 0);
    end
    checkOutput("abort_busy_after", 32'(busy), 0);
    checkOutput("abort_ready_after", 32'(req_ready), 1);
    for (int i = 0; i < 50; i++) model[i] = 2'd0;
    sweepModel("abort_sweep");

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/draw_grid_arbiter.md
DRAW_GRID_ARBITER -- requirements
Module: draw_grid_arbiter

Interface
REQ-001 Parameter GRID_W, default 10, number of grid columns.
REQ-002 Parameter GRID_H, default 10, number of grid rows; GRID_CELLS = GRID_W*GRID_H, addresses 0..GRID_CELLS-1.
REQ-003 clk  input  1  single clock, pixel (vga_clk) domain.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 disp_en  input  1  display reader owns the storage port this cycle.
REQ-006 disp_addr  input  7  cell address from the ship-drawing pipeline.
REQ-007 disp_status  output  2  cell status for disp_addr, one cycle after it is presented.
REQ-008 req_valid  input  1  game-logic request pending.
REQ-009 req_ready  output  1  arbiter can accept a request.
REQ-010 req_op  input  2  OP_WRITE, OP_SHOOT, OP_CLEAR (fourth code reserved).
REQ-011 req_addr  input  7  target cell (ignored for OP_CLEAR).
REQ-012 req_data  input  2  status to store (OP_WRITE only).
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_status  output  2  OP_SHOOT: cell status before the shot; OP_WRITE: req_data; OP_CLEAR: EMPTY.
REQ-015 resp_err  output  1  qualifies resp_valid; request had req_addr >= GRID_CELLS or reserved op.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 Storage SHALL be one single-port, synchronous-read, GRID_CELLS x 2-bit array; one read or one write per cycle.
REQ-018 Display SHALL have absolute priority: any cycle with disp_en=1 the port reads disp_addr and the FSM issues no access.
REQ-019 disp_status SHALL equal stored status of disp_addr one cycle after disp_en=1; EMPTY if that disp_addr >= GRID_CELLS or disp_en was 0.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge with req_valid & req_ready; req_* are sampled only then.
REQ-021 FSM states: IDLE, WR, RD, CHK, CLR, DONE.
REQ-022 IDLE -> WR on OP_WRITE, -> RD on OP_SHOOT, -> CLR on OP_CLEAR (clear counter = 0), -> DONE with resp_err=1 on bad address or reserved op (no storage access).
REQ-023 WR: write req_data when disp_en=0, then -> DONE; hold while disp_en=1.
REQ-024 RD: issue read when disp_en=0, then -> CHK; hold while disp_en=1.
REQ-025 CHK: capture old status; new status SHIP->HIT, EMPTY->MISS, HIT/MISS unchanged; -> WR if changed, else -> DONE.
REQ-026 CLR: write EMPTY at counter and increment on each disp_en=0 cycle; after writing GRID_CELLS-1 -> DONE; counter frozen while disp_en=1.
REQ-027 DONE: resp_valid=1 for exactly one cycle with resp_status/resp_err, -> IDLE.
REQ-028 With disp_en held 0, resp_valid SHALL rise 2 cycles after acceptance for OP_WRITE, 4 for a changing OP_SHOOT, 3 for an unchanged OP_SHOOT, GRID_CELLS+1 for OP_CLEAR, 1 for an error.
REQ-029 Each cycle of disp_en=1 while in WR, RD or CLR SHALL add exactly one cycle to latency; CHK and DONE are never stalled.

Reset
REQ-030 On rst=0: state IDLE, req_ready=0 during reset then 1, resp_valid=0, resp_status=EMPTY, resp_err=0, disp_status=EMPTY, busy=0, clear counter=0.
REQ-031 Array contents are not reset; software issues OP_CLEAR after reset.
REQ-032 Reset asserted mid-operation SHALL abort it with no resp_valid; partial CLR/WR results remain in the array.

Structure
REQ-033 Shared package holds grid_status_t (EMPTY=0, SHIP=1, HIT=2, MISS=3), grid_op_t, GRID_W, GRID_H, GRID_CELLS, address width.
REQ-034 The array SHALL be a sub-module grid_ram (single port: en, we, addr, wdata, rdata, 1-cycle read latency); FSM and port mux remain in draw_grid_arbiter.

Verification
REQ-035 disp_en=0; OP_CLEAR -> resp_valid at cycle 101, resp_status=EMPTY; disp_en=1 sweep 0..99 returns all EMPTY.
REQ-036 OP_WRITE addr 23 data SHIP, then OP_SHOOT addr 23 -> resp_status=SHIP; display read of 23 returns HIT; second OP_SHOOT 23 -> resp_status=HIT, latency 3.
REQ-037 OP_SHOOT addr 5 on EMPTY -> resp_status=EMPTY, cell 5 reads MISS.
REQ-038 OP_WRITE addr 7 with disp_en=1 for 10 cycles from acceptance -> resp_valid at cycle 12; disp_status correct throughout.
REQ-039 OP_WRITE addr 100 -> resp_valid, resp_err=1 next cycle; no cell changes.
REQ-040 Reset during OP_CLEAR at counter 50 -> no resp_valid; busy=0, req_ready=1 after release; cells 0..49 EMPTY.
